// File: rtl/bike_pkg.sv
// Shared types and constants for the speed display block.
package bike_pkg;

   localparam int BCD_DIGITS = 4;
   localparam int BIN_W      = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/speed_display_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module seg7_decode
   import bike_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Codes 10..15 never come out of the converter; show them blank.
   always_comb begin
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/speed_display.sv
// Four-digit multiplexed display of speed or distance.
// Captures a 10-bit value on upd, converts it to BCD by double-dabble
// (one bit per cycle), then loads it into the display register that the
// scan logic multiplexes onto the digits.
// Optional macro SPEED_DISPLAY_BLANK_EN: blank leading zeros on digits 3..1.
module speed_display
   import bike_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] speed,
   input  logic [BIN_W-1:0] num,
   input  logic             mode,
   input  logic             upd,
   output logic [7:0]       seg,
   output logic [3:0]       an,
   output logic             busy
);

   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BCD_W = 4 * BCD_DIGITS;

   state_t             state;
   logic [BIN_W-1:0]   bin;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   disp;
   logic               lmode;
   logic               dmode;
   logic [3:0]         cnt;
   logic [PRE_W-1:0]   pre;
   logic [1:0]         idx;
   logic [3:0]         nib;
   logic [6:0]         dec;
   logic               blank;

   // Double-dabble correction: add 3 to every nibble that is 5 or more.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < BCD_DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   // Conversion FSM: capture, shift BIN_W bits through, then load display.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         bin   <= '0;
         bcd   <= '0;
         lmode <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         disp  <= '0;
         dmode <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (upd) begin
                  bin   <= mode ? num : speed;
                  lmode <= mode;
                  bcd   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd <= {adj[BCD_W-2:0], bin[BIN_W-1]};
               bin <= {bin[BIN_W-2:0], 1'b0};
               cnt <= cnt + 4'd1;
               if (cnt == 4'(BIN_W - 1)) state <= LOAD;
            end
            LOAD: begin
               disp  <= bcd;
               dmode <= lmode;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Free-running scan prescaler and digit index.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
         pre <= '0;
         idx <= idx + 2'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   assign nib = disp[{idx, 2'b00} +: 4];

   seg7_decode u_dec (
      .nib (nib),
      .seg (dec)
   );

   // Leading-zero blanking: a digit blanks when it and all higher digits are 0.
   always_comb begin
      blank = 1'b0;
`ifdef SPEED_DISPLAY_BLANK_EN
      case (idx)
         2'd3:    blank = (disp[15:12] == 4'd0);
         2'd2:    blank = (disp[15:8]  == 8'd0);
         2'd1:    blank = (disp[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
`endif
   end

   assign an  = ~(4'b0001 << idx);
   assign seg = {~(dmode && (idx == 2'd1)), blank ? SEG_BLANK : dec};

endmodule

// File: tb/tb_speed_display.sv
// Self-checking bench for speed_display with SCAN_DIV=4.
module tb_speed_display;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] speed = '0;
   logic [9:0] num = '0;
   logic       mode = 1'b0;
   logic       upd = 1'b0;
   logic [7:0] seg;
   logic [3:0] an;
   logic       busy;

   int checks = 0;
   int failures = 0;

   speed_display #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .speed(speed), .num(num), .mode(mode),
      .upd(upd), .seg(seg), .an(an), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Reference: decimal digit d of value, with optional leading blank and dp.
   function automatic logic [7:0] exp_seg(int value, bit md, int d);
      int p;
      int dig;
      bit blk;
      p = 1;
      for (int k = 0; k < d; k++) p = p * 10;
      dig = (value / p) % 10;
      blk = 1'b0;
`ifdef SPEED_DISPLAY_BLANK_EN
      if (d > 0 && value < p) blk = 1'b1;
`endif
      return {~(md && d == 1), blk ? 7'h7F : tbl[dig]};
   endfunction

   // Sample one full scan (16 cycles) starting at the first cycle of digit 0.
   task automatic capture_scan(output logic [15:0][7:0] s, output logic [15:0][3:0] a,
                               output bit to);
      logic [3:0] prev;
      to = 1'b1;
      s  = '0;
      a  = '0;
      for (int k = 0; k < 40; k++) begin
         prev = an;
         @(negedge clk);
         if (prev == 4'b0111 && an == 4'b1110) begin
            to = 1'b0;
            break;
         end
      end
      if (!to)
         for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            s[i] = seg;
            a[i] = an;
         end
   endtask

   task automatic test_reset();
      rst = 1'b0; upd = 1'b1; speed = 10'd555; mode = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b exp=1110", an); end
      checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL reset_seg got=%h exp=c0", seg); end
      rst = 1'b1; upd = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_upd_ignored busy=%b exp=0", busy); end
   endtask

   // Capture a value, check the busy window and the full scan afterwards.
   task automatic test_value(string name, int sp, int nm, bit md);
      int bc;
      int v;
      logic [15:0][7:0] s;
      logic [15:0][3:0] a;
      logic [3:0] ea;
      bit to;
      v = md ? nm : sp;
      speed = 10'(sp); num = 10'(nm); mode = md; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      // Inputs moving after capture must not leak into the result.
      speed = 10'($urandom_range(0, 1023)); num = 10'($urandom_range(0, 1023));
      bc = 0;
      while (busy === 1'b1 && bc < 40) begin bc++; @(negedge clk); end
      checks++; if (bc != 11) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=11", name, bc); end
      capture_scan(s, a, to);
      checks++; if (to) begin failures++; $display("FAIL %s_scan_timeout got=timeout exp=scan", name); end
      for (int i = 0; i < 16; i++) begin
         ea = ~(4'b0001 << (i / 4));
         checks++;
         if (a[i] !== ea || s[i] !== exp_seg(v, md, i / 4)) begin
            failures++;
            $display("FAIL %s_scan[%0d] got an=%b seg=%h exp an=%b seg=%h",
                     name, i, a[i], s[i], ea, exp_seg(v, md, i / 4));
         end
      end
   endtask

   task automatic test_drop();
      int bc;
      int hi;
      int v;
      logic [15:0][7:0] s;
      logic [15:0][3:0] a;
      logic [3:0] ea;
      bit to;
      v = $urandom_range(100, 999);
      speed = 10'(v); mode = 1'b0; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_at_2nd got=%b exp=1", busy); end
      speed = 10'd42; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      bc = 0;
      while (busy === 1'b1 && bc < 40) begin bc++; @(negedge clk); end
      hi = 0;
      for (int k = 0; k < 15; k++) begin if (busy !== 1'b0) hi++; @(negedge clk); end
      checks++; if (hi != 0) begin failures++; $display("FAIL drop_not_queued busy_cycles=%0d exp=0", hi); end
      capture_scan(s, a, to);
      checks++; if (to) begin failures++; $display("FAIL drop_scan_timeout got=timeout exp=scan"); end
      for (int i = 0; i < 16; i++) begin
         ea = ~(4'b0001 << (i / 4));
         checks++;
         if (a[i] !== ea || s[i] !== exp_seg(v, 1'b0, i / 4)) begin
            failures++;
            $display("FAIL drop_scan[%0d] got an=%b seg=%h exp an=%b seg=%h",
                     i, a[i], s[i], ea, exp_seg(v, 1'b0, i / 4));
         end
      end
   endtask

   task automatic test_reset_mid();
      int hi;
      logic [15:0][7:0] s;
      logic [15:0][3:0] a;
      logic [3:0] ea;
      bit to;
      speed = 10'd876; mode = 1'b0; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      rst = 1'b1;
      hi = 0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (busy !== 1'b0) hi++; end
      checks++; if (hi != 0) begin failures++; $display("FAIL midrst_no_resume busy_cycles=%0d exp=0", hi); end
      capture_scan(s, a, to);
      checks++; if (to) begin failures++; $display("FAIL midrst_scan_timeout got=timeout exp=scan"); end
      for (int i = 0; i < 16; i++) begin
         ea = ~(4'b0001 << (i / 4));
         checks++;
         if (a[i] !== ea || s[i] !== exp_seg(0, 1'b0, i / 4)) begin
            failures++;
            $display("FAIL midrst_scan[%0d] got an=%b seg=%h exp an=%b seg=%h",
                     i, a[i], s[i], ea, exp_seg(0, 1'b0, i / 4));
         end
      end
   endtask

   task automatic test_mode_toggle();
      int v;
      logic [15:0][7:0] s;
      logic [15:0][3:0] a;
      logic [3:0] ea;
      bit to;
      v = $urandom_range(10, 1023);
      test_value("toggle_pre", v, $urandom_range(0, 1023), 1'b0);
      mode = 1'b1;
      speed = 10'($urandom_range(0, 1023)); num = 10'($urandom_range(0, 1023));
      capture_scan(s, a, to);
      checks++; if (to) begin failures++; $display("FAIL toggle_scan_timeout got=timeout exp=scan"); end
      for (int i = 0; i < 16; i++) begin
         ea = ~(4'b0001 << (i / 4));
         checks++;
         if (a[i] !== ea || s[i] !== exp_seg(v, 1'b0, i / 4)) begin
            failures++;
            $display("FAIL toggle_scan[%0d] got an=%b seg=%h exp an=%b seg=%h",
                     i, a[i], s[i], ea, exp_seg(v, 1'b0, i / 4));
         end
      end
      mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_value("spd375", 375, $urandom_range(0, 1023), 1'b0);
      test_value("num1023", $urandom_range(0, 1023), 1023, 1'b1);
      test_value("zero", 0, 0, 1'b0);
      for (int r = 0; r < 4; r++)
         test_value("rand", $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
      test_drop();
      test_value("num_dp", 0, $urandom_range(100, 999), 1'b1);
      test_reset_mid();
      test_value("blank7", 7, $urandom_range(0, 1023), 1'b0);
      test_mode_toggle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
